// File: rtl/unary_frame_generator_pkg.sv
// Shared definitions for the unary frame generator: FSM state encoding,
// default geometry and the count saturation helper. The bench imports this too.
package unary_frame_generator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int FRAME_DEF = 3;
  localparam int CW_DEF    = 2;
  // Slot index width: wide enough for the largest legal frame (15 slots).
  localparam int SLOT_W    = 4;

  // Clamp a requested count to the frame length.
  function automatic logic [31:0] sat_count(input logic [31:0] count,
                                            input logic [31:0] frame);
    logic [31:0] res;
    if (count > frame) begin
      res = frame;
    end else begin
      res = count;
    end
    return res;
  endfunction

endpackage

// File: rtl/unary_frame_generator_if.sv
// Handshake bundle between a count producer / slot consumer and the generator.
// master = the side that offers counts and consumes slots; slave = the generator.
interface unary_frame_generator_if
  import unary_frame_generator_pkg::*;
#(
  parameter int CW = CW_DEF
) ();

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] count;
  logic          mode;
  logic          out_ready;
  logic          ser_out;
  logic          ser_valid;
  logic          frame_start;
  logic          frame_done;
  logic          sat_err;

  modport master (
    output in_valid, count, mode, out_ready,
    input  in_ready, ser_out, ser_valid, frame_start, frame_done, sat_err
  );

  modport slave (
    input  in_valid, count, mode, out_ready,
    output in_ready, ser_out, ser_valid, frame_start, frame_done, sat_err
  );

endinterface

// File: rtl/unary_frame_generator_slot_decode.sv
// Combinational slot decoder: given the saturated count, the fill mode and a
// slot index, tells whether that slot carries a one.
module unary_slot_decode
  import unary_frame_generator_pkg::*;
#(
  parameter int FRAME = FRAME_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic [CW-1:0]     cnt_i,
  input  logic              mode_i,
  input  logic [SLOT_W-1:0] slot_i,
  output logic              bit_o
);

  logic [31:0] slot_w;
  logic [31:0] cnt_w;
  logic [31:0] thr_w;

  // Mode 0 fills the leading slots, mode 1 the trailing ones; cnt <= FRAME so thr never wraps.
  always_comb begin
    slot_w = 32'(slot_i);
    cnt_w  = 32'(cnt_i);
    thr_w  = 32'(FRAME) - cnt_w;
    if (mode_i) begin
      bit_o = (slot_w >= thr_w);
    end else begin
      bit_o = (slot_w < cnt_w);
    end
  end

endmodule

// File: rtl/unary_frame_generator.sv
// Unary frame generator: accepts a count word and serialises it as FRAME
// slots holding exactly cnt ones, packed at the front (mode 0) or back
// (mode 1). Back-to-back frames are chained without a gap when a new count
// is offered on the last slot.
module unary_frame_generator
  import unary_frame_generator_pkg::*;
#(
  parameter int FRAME = FRAME_DEF,
  parameter int CW    = CW_DEF
) (
  input logic                   clk,
  input logic                   rst,
  unary_frame_generator_if.slave bus
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME - 1);
  localparam logic [SLOT_W-1:0] FIRST_SLOT = {SLOT_W{1'b0}};

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              sat_q, sat_d;

  logic              ser_out_q, ser_out_d;
  logic              ser_valid_q, ser_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic              sat_err_q, sat_err_d;

  logic              in_ready_s;
  logic              accept_s;
  logic              last_s;
  logic [CW-1:0]     count_sat_s;
  logic              count_over_s;
  logic              slot_bit_s;

  // Bit for the slot that will be presented after the next edge.
  unary_slot_decode #(
    .FRAME (FRAME),
    .CW    (CW)
  ) u_decode (
    .cnt_i  (cnt_d),
    .mode_i (mode_d),
    .slot_i (slot_d),
    .bit_o  (slot_bit_s)
  );

  // Ready is combinational on out_ready so a new count can chain onto the last slot.
  always_comb begin
    last_s       = (slot_q == LAST_SLOT);
    count_over_s = (32'(bus.count) > 32'(FRAME));
    count_sat_s  = CW'(sat_count(32'(bus.count), 32'(FRAME)));
    if (state_q == IDLE) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = last_s && bus.out_ready;
    end
    accept_s = bus.in_valid && in_ready_s;
  end

  // Next-state logic for the FSM, slot counter and latched frame parameters.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = EMIT;
          slot_d  = FIRST_SLOT;
          cnt_d   = count_sat_s;
          mode_d  = bus.mode;
          sat_d   = count_over_s;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (!bus.out_ready) begin
          // Stall: everything holds, outputs recompute to the same values.
          slot_d = slot_q;
        end else if (!last_s) begin
          slot_d = slot_q + SLOT_W'(1);
        end else if (accept_s) begin
          slot_d = FIRST_SLOT;
          cnt_d  = count_sat_s;
          mode_d = bus.mode;
          sat_d  = count_over_s;
        end else begin
          state_d = IDLE;
          slot_d  = FIRST_SLOT;
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = FIRST_SLOT;
      end
    endcase
  end

  // Output values for the slot presented after the next edge.
  always_comb begin
    ser_valid_d   = 1'b0;
    ser_out_d     = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    sat_err_d     = 1'b0;
    if (state_d == EMIT) begin
      ser_valid_d   = 1'b1;
      ser_out_d     = slot_bit_s;
      frame_start_d = (slot_d == FIRST_SLOT);
      frame_done_d  = (slot_d == LAST_SLOT);
      sat_err_d     = (slot_d == FIRST_SLOT) && sat_d;
    end else begin
      ser_valid_d   = 1'b0;
    end
  end

  // State, parameter and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= FIRST_SLOT;
      cnt_q         <= {CW{1'b0}};
      mode_q        <= 1'b0;
      sat_q         <= 1'b0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      sat_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      sat_q         <= sat_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      sat_err_q     <= sat_err_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.ser_out     = ser_out_q;
  assign bus.ser_valid   = ser_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.sat_err     = sat_err_q;

endmodule

// File: doc/unary_frame_generator.md
UNARY_FRAME_GENERATOR -- requirements
Module: unary_frame_generator

Interface
REQ-001 SHALL have parameter FRAME, default 3: slots per output frame, legal range 1..15.
REQ-002 SHALL have parameter CW, default 2: count width, sized so 2^CW-1 >= FRAME.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk  input  1: rising-edge clock.
REQ-005 Port rst  input  1: synchronous active-high reset.
REQ-006 Port in_valid  input  1: count word offered.
REQ-007 Port in_ready  output  1: block accepts a count this cycle.
REQ-008 Port count  input  CW: number of ones to emit in the frame.
REQ-009 Port mode  input  1: 0 = ones in first slots, 1 = ones in last slots; sampled with count.
REQ-010 Port out_ready  input  1: consumer accepts the current slot.
REQ-011 Port ser_out  output  1: current slot bit.
REQ-012 Port ser_valid  output  1: ser_out is a valid slot.
REQ-013 Port frame_start  output  1: current slot is slot 0.
REQ-014 Port frame_done  output  1: current slot is slot FRAME-1.
REQ-015 Port sat_err  output  1: accepted count exceeded FRAME.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and EMIT.
REQ-017 Accept condition: in_valid && in_ready; count and mode are latched on accept.
REQ-018 in_ready SHALL be 1 in IDLE, and 1 in EMIT only when the slot is FRAME-1 and out_ready=1; otherwise 0.
REQ-019 Transition IDLE->EMIT on accept; slot index 0 is presented the next cycle.
REQ-020 In EMIT, the slot index SHALL advance only when out_ready=1; while out_ready=0, ser_out, ser_valid, frame_start and frame_done SHALL hold.
REQ-021 Slot i bit: mode 0 -> 1 iff i < cnt; mode 1 -> 1 iff i >= FRAME-cnt.
REQ-022 At the last slot with out_ready=1: with a simultaneous accept, go to slot 0 of the new frame with no gap; otherwise return to IDLE.
REQ-023 Latency: accept at cycle t gives slot 0 at t+1; with out_ready held 1, the last slot is at t+FRAME.
REQ-024 If count > FRAME, cnt SHALL saturate to FRAME, and sat_err SHALL be 1 for exactly the cycles slot 0 of that frame is presented.
REQ-025 count = 0 SHALL emit FRAME zero slots with ser_valid=1.
REQ-026 In IDLE: ser_valid=0, ser_out=0, frame_start=0, frame_done=0, sat_err=0.
REQ-027 For FRAME=1, frame_start and frame_done SHALL both be 1 on the single slot.
REQ-028 The number of ones in a frame SHALL always equal the saturated cnt, so a 3-input ones counter fed the FRAME=3 slots returns cnt.

Reset
REQ-029 rst=1 SHALL force IDLE, clear the slot index, cnt and mode registers, and drive in_ready=1 and all other outputs to 0 on the next edge.
REQ-030 rst during EMIT SHALL abort the frame immediately; no partial-frame completion.
REQ-031 rst SHALL take priority over accept and out_ready in the same cycle.

Structure
REQ-032 A shared include file SHALL hold the state encodings (IDLE=0, EMIT=1) and the FRAME/CW defaults, used by both RTL and bench.
REQ-033 One sub-module is natural: unary_slot_decode (combinational cnt, mode, slot index -> bit); everything else stays in the top module.
REQ-034 Only the FSM, slot counter, cnt/mode/sat registers and output registers are sequential.

Verification
REQ-035 FRAME=3, out_ready=1, accept count=2 mode=0 at t -> ser_out 1,1,0 at t+1..t+3; frame_start at t+1; frame_done at t+3; in_ready=1 at t+3.
REQ-036 FRAME=3, accept count=1 mode=1, then count=3 mode=0 on the last slot -> ser_out 0,0,1,1,1,1 on consecutive cycles; ser_valid never drops.
REQ-037 FRAME=3, count=2 mode=0, out_ready=0 for 4 cycles during slot 1 -> slot 1 held (ser_out=1, ser_valid=1), then slot 2 = 0; in_ready stays 0 throughout the stall.
REQ-038 FRAME=5 (CW=3), count=7 -> five 1 slots; sat_err=1 only on slot 0.
REQ-039 Assert rst during slot 1 of a frame -> next cycle IDLE, ser_valid=0, in_ready=1; a new count=1 is then accepted and emitted normally.
REQ-040 Round trip: for all count 0..3 and both modes, feed the three slots into a 3-input ones counter -> {y1,y0} == count.
